// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types for the bit-serial subtractor
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor (a - b - bin)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, start/busy/done
// Optional signed-overflow output Ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             Borrow
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bff_q, bff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic d_bit, bout_bit;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (bff_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        bff_d    = bff_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = A;
                    b_sr_d  = B;
                    bff_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
                res_sr_d = {d_bit, res_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                bff_d    = bout_bit;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                diff_d   = res_sr_q;
                borrow_d = bff_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d    = (a_msb_q ^ b_msb_q) & (res_sr_q[WIDTH-1] ^ a_msb_q);
`endif
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            bff_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            bff_q    <= bff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Diff   = diff_q;
    assign Borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign Ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (a_in),
        .B      (b_in),
        .busy   (busy),
        .done   (done),
        .Diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
        .Ovf    (ovf),
`endif
        .Borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle.
    task automatic do_op(input vec_t v, input string nm);
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            if (i > 0) @(negedge clk);
            check({nm, "_busy"}, {31'd0, busy}, 32'd1);
            check({nm, "_nodone"}, {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check({nm, "_done"}, {31'd0, done}, 32'd1);
        check({nm, "_idle"}, {31'd0, busy}, 32'd0);
        check({nm, "_diff"}, {28'd0, diff}, {28'd0, v.diff});
        check({nm, "_borrow"}, {31'd0, borrow}, {31'd0, v.borrow});
`ifdef SERIAL_SUB_OVF_EN
        check({nm, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
        @(negedge clk);
        check({nm, "_pulse"}, {31'd0, done}, 32'd0);
        check({nm, "_hold"}, {28'd0, diff}, {28'd0, v.diff});
    endtask

    initial begin
        vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd9,  4'hA,  1'b1, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0};
        vecs[4] = '{4'd0,  4'd1,  4'hF,  1'b1, 1'b0};
        vecs[5] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
        vecs[6] = '{4'd5,  4'd2,  4'd3,  1'b0, 1'b0};
        vecs[7] = '{4'd7,  4'hF,  4'd8,  1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {28'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // start held high: one operation per WIDTH+2 cycles, mid-op start ignored
        a_in  = 4'd5;
        b_in  = 4'd2;
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            check($sformatf("cont_done%0d", n), {31'd0, done}, {31'd0, (n % 6) == 0});
            if ((n % 6) == 0) check($sformatf("cont_diff%0d", n), {28'd0, diff}, 32'd3);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // operands changed after capture
        a_in  = 4'd9;
        b_in  = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (W) @(negedge clk);
        @(negedge clk);
        check("capt_done", {31'd0, done}, 32'd1);
        check("capt_diff", {28'd0, diff}, 32'd6);
        check("capt_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);

        // reset during the second SHIFT cycle aborts the operation
        a_in  = 4'd3;
        b_in  = 4'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {28'd0, diff}, 32'd0);
        check("abort_borrow", {31'd0, borrow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < W + 3; n++) begin
            @(negedge clk);
            check($sformatf("abort_nodone%0d", n), {31'd0, done}, 32'd0);
            check($sformatf("abort_idle%0d", n), {31'd0, busy}, 32'd0);
        end
        do_op(vecs[1], "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
